// File: rtl/mips_mc_controller.sv
// Multicycle Moore control FSM for the MIPS core with memory wait states, timeout and sub-word access.
// Optional feature: define MIPS_MC_LINK_EN to implement jal; otherwise jal is an illegal opcode.
module mips_mc_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       link,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] alucontrol,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [1:0] half,
  output logic       lbu,
  output logic       instr_done,
  output logic       trap
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_MC_LINK_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam bit             TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPE, S_ALUWB,
    S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_JR, S_JAL, S_TRAP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_trap;

  logic             w_is_load;
  logic             w_is_store;
  logic             w_funct_ok;
  logic [3:0]       w_rt_alu;
  logic [1:0]       w_half;
  logic             w_lbu;
  logic             w_timeout;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_pcwrite;
  logic             w_branch;
  logic             w_ne;

  assign w_is_load  = (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) || (op == OP_LH);
  assign w_is_store = (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
  // The final wait cycle times out only if memory still has not answered.
  assign w_timeout  = TO_EN && (r_wait_cnt == TO_LAST) && !mem_ready;
  assign w_cnt_inc  = (&r_wait_cnt) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);

  always_comb begin
    w_funct_ok = 1'b1;
    w_rt_alu   = ALU_ADD;
    case (funct)
      FN_ADD:  w_rt_alu = ALU_ADD;
      FN_SUB:  w_rt_alu = ALU_SUB;
      FN_AND:  w_rt_alu = ALU_AND;
      FN_OR:   w_rt_alu = ALU_OR;
      FN_SLT:  w_rt_alu = ALU_SLT;
      default: w_funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_half = 2'b00;
    w_lbu  = 1'b0;
    case (op)
      OP_LB, OP_SB: w_half = 2'b10;
      OP_LBU: begin
        w_half = 2'b10;
        w_lbu  = 1'b1;
      end
      OP_LH, OP_SH: w_half = 2'b01;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_trap     <= 1'b0;
    end else begin
      r_wait_cnt <= '0;
      case (r_state)
        S_FETCH, S_MEMRD, S_MEMWR: begin
          if (mem_ready) begin
            if (r_state == S_FETCH)      r_state <= S_DECODE;
            else if (r_state == S_MEMRD) r_state <= S_MEMWB;
            else                         r_state <= S_FETCH;
          end else if (w_timeout) begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
          end else begin
            r_wait_cnt <= w_cnt_inc;
          end
        end
        S_DECODE: begin
          if (op == OP_RTYPE)                  r_state <= (funct == FN_JR) ? S_JR : S_RTYPE;
          else if (w_is_load || w_is_store)    r_state <= S_MEMADR;
          else if (op == OP_BEQ || op == OP_BNE) r_state <= S_BRANCH;
          else if (op == OP_ADDI)              r_state <= S_ADDIEX;
          else if (op == OP_J)                 r_state <= S_JUMP;
`ifdef MIPS_MC_LINK_EN
          else if (op == OP_JAL)               r_state <= S_JAL;
`endif
          else begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
          end
        end
        S_MEMADR: r_state <= w_is_load ? S_MEMRD : S_MEMWR;
        S_RTYPE: begin
          if (w_funct_ok) begin
            r_state <= S_ALUWB;
          end else begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
          end
        end
        S_ADDIEX: r_state <= S_ADDIWB;
        S_TRAP:   r_state <= S_TRAP;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Moore decode; reset forces every strobe low so an aborted instruction writes nothing.
  always_comb begin
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    link       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = 4'b0000;
    pcsrc      = 2'b00;
    half       = 2'b00;
    lbu        = 1'b0;
    instr_done = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_ne       = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alusrcb    = 2'b01;
          alucontrol = ALU_ADD;
          irwrite    = mem_ready;
          w_pcwrite  = mem_ready;
        end
        S_DECODE: begin
          alusrcb    = 2'b11;
          alucontrol = ALU_ADD;
        end
        S_MEMADR, S_ADDIEX: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = ALU_ADD;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          half    = w_half;
          lbu     = w_lbu;
        end
        S_MEMWB: begin
          memtoreg   = 1'b1;
          regwrite   = 1'b1;
          half       = w_half;
          lbu        = w_lbu;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_req    = 1'b1;
          memwrite   = 1'b1;
          iord       = 1'b1;
          half       = w_half;
          instr_done = mem_ready;
        end
        S_RTYPE: begin
          alusrca    = 1'b1;
          alucontrol = w_rt_alu;
        end
        S_ALUWB: begin
          regdst     = 1'b1;
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alusrca    = 1'b1;
          alucontrol = ALU_SUB;
          pcsrc      = 2'b01;
          w_branch   = 1'b1;
          w_ne       = (op == OP_BNE);
          instr_done = 1'b1;
        end
        S_ADDIWB: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pcsrc      = 2'b10;
          w_pcwrite  = 1'b1;
          instr_done = 1'b1;
        end
        S_JR: begin
          pcsrc      = 2'b11;
          w_pcwrite  = 1'b1;
          instr_done = 1'b1;
        end
`ifdef MIPS_MC_LINK_EN
        S_JAL: begin
          regwrite   = 1'b1;
          link       = 1'b1;
          pcsrc      = 2'b10;
          w_pcwrite  = 1'b1;
          instr_done = 1'b1;
        end
`endif
        default: ;
      endcase
    end
    pcen = w_pcwrite | (w_branch & (zero ^ w_ne));
    trap = r_trap & ~reset;
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed table-driven bench for mips_mc_controller plus hand sequences for timeout and trap behaviour.
// Honours MIPS_MC_LINK_EN for the jal expectations.
module tb_mips_mc_controller;

  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       link;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [3:0] alucontrol;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [1:0] half;
    logic       lbu;
    logic       instr_done;
    logic       trap;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       rdy;
    outs_t      exp;
    bit         chk;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite, link;
  logic       alusrca, pcen, lbu, instr_done, trap;
  logic [1:0] alusrcb, pcsrc, half;
  logic [3:0] alucontrol;
  outs_t      got;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  mips_mc_controller #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .link(link), .alusrca(alusrca), .alusrcb(alusrcb),
    .alucontrol(alucontrol), .pcsrc(pcsrc), .pcen(pcen), .half(half), .lbu(lbu),
    .instr_done(instr_done), .trap(trap)
  );

  always #5 clk = ~clk;

  assign got = '{mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite, link, alusrca,
                 alusrcb, alucontrol, pcsrc, pcen, half, lbu, instr_done, trap};

  function automatic outs_t o_fetch(input logic rdy);
    outs_t o = '0;
    o.mem_req = 1'b1; o.alusrcb = 2'b01; o.alucontrol = 4'b0010;
    o.irwrite = rdy;  o.pcen = rdy;
    return o;
  endfunction
  function automatic outs_t o_decode();
    outs_t o = '0;
    o.alusrcb = 2'b11; o.alucontrol = 4'b0010;
    return o;
  endfunction
  function automatic outs_t o_memadr();
    outs_t o = '0;
    o.alusrca = 1'b1; o.alusrcb = 2'b10; o.alucontrol = 4'b0010;
    return o;
  endfunction
  function automatic outs_t o_rtype(input logic [3:0] ctl);
    outs_t o = '0;
    o.alusrca = 1'b1; o.alucontrol = ctl;
    return o;
  endfunction
  function automatic outs_t o_aluwb();
    outs_t o = '0;
    o.regdst = 1'b1; o.regwrite = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_memrd(input logic [1:0] h, input logic u);
    outs_t o = '0;
    o.mem_req = 1'b1; o.iord = 1'b1; o.half = h; o.lbu = u;
    return o;
  endfunction
  function automatic outs_t o_memwb(input logic [1:0] h, input logic u);
    outs_t o = '0;
    o.memtoreg = 1'b1; o.regwrite = 1'b1; o.half = h; o.lbu = u; o.instr_done = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_memwr(input logic [1:0] h, input logic rdy);
    outs_t o = '0;
    o.mem_req = 1'b1; o.memwrite = 1'b1; o.iord = 1'b1; o.half = h; o.instr_done = rdy;
    return o;
  endfunction
  function automatic outs_t o_branch(input logic pe);
    outs_t o = '0;
    o.alusrca = 1'b1; o.alucontrol = 4'b0110; o.pcsrc = 2'b01; o.pcen = pe; o.instr_done = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_addiwb();
    outs_t o = '0;
    o.regwrite = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_jump(input logic [1:0] src);
    outs_t o = '0;
    o.pcsrc = src; o.pcen = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_jal();
    outs_t o = '0;
    o.regwrite = 1'b1; o.link = 1'b1; o.pcsrc = 2'b10; o.pcen = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_trap();
    outs_t o = '0;
    o.trap = 1'b1;
    return o;
  endfunction

  task automatic add(input logic rst, input logic [5:0] o, input logic [5:0] f, input logic z,
                     input logic r, input outs_t e, input bit c);
    vec_t v;
    v.rst = rst; v.op = o; v.funct = f; v.zero = z; v.rdy = r; v.exp = e; v.chk = c;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic [5:0] o, input logic [5:0] f, input logic r);
    reset = rst; op = o; funct = f; mem_ready = r;
  endtask

  task automatic chk1(input string name, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, a, e);
    end
  endtask

  task automatic rtype_seq(input logic [5:0] f, input logic [3:0] ctl);
    add(0, 6'b000000, f, 0, 1, o_fetch(1), 1);
    add(0, 6'b000000, f, 0, 1, o_decode(), 1);
    add(0, 6'b000000, f, 0, 1, o_rtype(ctl), 1);
    add(0, 6'b000000, f, 0, 1, o_aluwb(), 1);
  endtask

  task automatic branch_seq(input logic [5:0] o, input logic z, input logic pe);
    add(0, o, 0, z, 1, o_fetch(1), 1);
    add(0, o, 0, z, 1, o_decode(), 1);
    add(0, o, 0, z, 1, o_branch(pe), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset holds all outputs low
    add(1, 0, 0, 0, 1, '0, 1);
    add(1, 0, 0, 0, 1, '0, 1);
    rtype_seq(6'b100000, 4'b0010);
    rtype_seq(6'b100010, 4'b0110);
    rtype_seq(6'b100100, 4'b0000);
    rtype_seq(6'b100101, 4'b0001);
    rtype_seq(6'b101010, 4'b0111);
    // lw with three wait states in MEMRD: 8 cycles total
    add(0, 6'b100011, 0, 0, 1, o_fetch(1), 1);
    add(0, 6'b100011, 0, 0, 1, o_decode(), 1);
    add(0, 6'b100011, 0, 0, 1, o_memadr(), 1);
    add(0, 6'b100011, 0, 0, 0, o_memrd(2'b00, 0), 1);
    add(0, 6'b100011, 0, 0, 0, o_memrd(2'b00, 0), 1);
    add(0, 6'b100011, 0, 0, 0, o_memrd(2'b00, 0), 1);
    add(0, 6'b100011, 0, 0, 1, o_memrd(2'b00, 0), 1);
    add(0, 6'b100011, 0, 0, 0, o_memwb(2'b00, 0), 1);
    branch_seq(6'b000100, 1, 1);
    branch_seq(6'b000101, 1, 0);
    branch_seq(6'b000100, 0, 0);
    branch_seq(6'b000101, 0, 1);
    // lbu
    add(0, 6'b100100, 0, 0, 1, o_fetch(1), 1);
    add(0, 6'b100100, 0, 0, 1, o_decode(), 1);
    add(0, 6'b100100, 0, 0, 1, o_memadr(), 1);
    add(0, 6'b100100, 0, 0, 1, o_memrd(2'b10, 1), 1);
    add(0, 6'b100100, 0, 0, 1, o_memwb(2'b10, 1), 1);
    // sh with one wait state
    add(0, 6'b101001, 0, 0, 1, o_fetch(1), 1);
    add(0, 6'b101001, 0, 0, 1, o_decode(), 1);
    add(0, 6'b101001, 0, 0, 1, o_memadr(), 1);
    add(0, 6'b101001, 0, 0, 0, o_memwr(2'b01, 0), 1);
    add(0, 6'b101001, 0, 0, 1, o_memwr(2'b01, 1), 1);
    // sw
    add(0, 6'b101011, 0, 0, 1, o_fetch(1), 1);
    add(0, 6'b101011, 0, 0, 1, o_decode(), 1);
    add(0, 6'b101011, 0, 0, 1, o_memadr(), 1);
    add(0, 6'b101011, 0, 0, 1, o_memwr(2'b00, 1), 1);
    // addi
    add(0, 6'b001000, 0, 0, 1, o_fetch(1), 1);
    add(0, 6'b001000, 0, 0, 1, o_decode(), 1);
    add(0, 6'b001000, 0, 0, 1, o_memadr(), 1);
    add(0, 6'b001000, 0, 0, 1, o_addiwb(), 1);
    // j with two fetch wait states
    add(0, 6'b000010, 0, 0, 0, o_fetch(0), 1);
    add(0, 6'b000010, 0, 0, 0, o_fetch(0), 1);
    add(0, 6'b000010, 0, 0, 1, o_fetch(1), 1);
    add(0, 6'b000010, 0, 0, 1, o_decode(), 1);
    add(0, 6'b000010, 0, 0, 1, o_jump(2'b10), 1);
    // jr
    add(0, 6'b000000, 6'b001000, 0, 1, o_fetch(1), 1);
    add(0, 6'b000000, 6'b001000, 0, 1, o_decode(), 1);
    add(0, 6'b000000, 6'b001000, 0, 1, o_jump(2'b11), 1);
    // reset during MEMWB aborts the register write
    add(0, 6'b100011, 0, 0, 1, o_fetch(1), 1);
    add(0, 6'b100011, 0, 0, 1, o_decode(), 1);
    add(0, 6'b100011, 0, 0, 1, o_memadr(), 1);
    add(0, 6'b100011, 0, 0, 1, o_memrd(2'b00, 0), 1);
    add(1, 6'b100011, 0, 0, 1, '0, 1);
    add(0, 6'b100011, 0, 0, 0, o_fetch(0), 1);
    add(0, 6'b100011, 0, 0, 1, o_fetch(1), 1);
    add(0, 6'b100011, 0, 0, 1, o_decode(), 1);
    add(1, 6'b100011, 0, 0, 1, '0, 1);
    // illegal funct
    add(0, 6'b000000, 6'b000000, 0, 1, o_fetch(1), 1);
    add(0, 6'b000000, 6'b000000, 0, 1, o_decode(), 1);
    add(0, 6'b000000, 6'b000000, 0, 1, '0, 0);
    add(0, 6'b000000, 6'b000000, 0, 1, o_trap(), 1);
    add(0, 6'b000000, 6'b000000, 0, 1, o_trap(), 1);
    add(1, 6'b000000, 6'b000000, 0, 1, '0, 1);
    // illegal opcode
    add(0, 6'b111111, 0, 0, 1, o_fetch(1), 1);
    add(0, 6'b111111, 0, 0, 1, o_decode(), 1);
    add(0, 6'b111111, 0, 0, 1, o_trap(), 1);
    add(0, 6'b111111, 0, 0, 1, o_trap(), 1);
    add(1, 6'b111111, 0, 0, 1, '0, 1);
    // jal
    add(0, 6'b000011, 0, 0, 1, o_fetch(1), 1);
    add(0, 6'b000011, 0, 0, 1, o_decode(), 1);
`ifdef MIPS_MC_LINK_EN
    add(0, 6'b000011, 0, 0, 1, o_jal(), 1);
    add(0, 6'b000011, 0, 0, 0, o_fetch(0), 1);
`else
    add(0, 6'b000011, 0, 0, 1, o_trap(), 1);
    add(0, 6'b000011, 0, 0, 0, o_trap(), 1);
`endif
    add(1, 6'b000011, 0, 0, 1, '0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].funct, vecs[i].rdy);
      zero = vecs[i].zero;
      @(negedge clk);
      if (vecs[i].chk) begin
        checks++;
        if (got !== vecs[i].exp) begin
          failures++;
          $display("FAIL vec%0d op=%b funct=%b got=%h exp=%h", i, vecs[i].op, vecs[i].funct,
                   got, vecs[i].exp);
        end
      end
      @(posedge clk); #1;
    end

    // FETCH timeout: trap appears on cycle 17 and sticks, irwrite never fires
    drive(1, 6'b000000, 6'b100000, 0);
    @(posedge clk); #1;
    drive(0, 6'b000000, 6'b100000, 0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      chk1($sformatf("fetch_to_trap_c%0d", c), trap, c >= 17);
      chk1($sformatf("fetch_to_irwrite_c%0d", c), irwrite, 1'b0);
      chk1($sformatf("fetch_to_memreq_c%0d", c), mem_req, c <= 16);
      @(posedge clk); #1;
    end
    drive(1, 6'b000000, 6'b100000, 0);
    @(negedge clk);
    chk1("trap_during_reset", trap, 1'b0);
    @(posedge clk); #1;
    drive(0, 6'b000000, 6'b100000, 0);
    @(negedge clk);
    chk1("trap_after_reset", trap, 1'b0);
    chk1("memreq_after_reset", mem_req, 1'b1);
    @(posedge clk); #1;

    // mem_ready on the timeout cycle completes the fetch
    drive(1, 6'b000000, 6'b100000, 0);
    @(posedge clk); #1;
    for (int c = 1; c <= 17; c++) begin
      drive(0, 6'b000000, 6'b100000, c == 16);
      @(negedge clk);
      if (c == 16) chk1("ready_wins_irwrite", irwrite, 1'b1);
      if (c == 17) begin
        chk1("ready_wins_trap", trap, 1'b0);
        chk1("ready_wins_decode", alusrcb == 2'b11, 1'b1);
      end
      @(posedge clk); #1;
    end

    // MEMRD timeout: no register write, trap after 16 wait cycles
    drive(1, 6'b100011, 6'b000000, 1);
    @(posedge clk); #1;
    for (int c = 1; c <= 21; c++) begin
      drive(0, 6'b100011, 6'b000000, c == 1);
      @(negedge clk);
      if (c >= 4) begin
        chk1($sformatf("memrd_to_trap_c%0d", c), trap, c >= 20);
        chk1($sformatf("memrd_to_memreq_c%0d", c), mem_req, c <= 19);
        chk1($sformatf("memrd_to_regwrite_c%0d", c), regwrite, 1'b0);
      end
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
